rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit output bus (e.g. the top-level 16-bit data port) between NREQ streaming requesters.
- Grants one requester at a time, passes its valid/data/last through to the shared bus, and applies downstream backpressure to that requester only.
- Caps each grant at MAX_BURST beats so that no single requester can starve the others.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 16, data width per requester and of the shared bus.
- MAX_BURST, 4, maximum beats per grant before forced release (1..255).
- SW, $clog2(NREQ), width of the source index (derived; not overridable).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_data  input  NREQ*DW  packed requester data; requester i occupies bits [i*DW +: DW].
- req_last  input  NREQ  per-requester end-of-packet flag.
- req_ready  output  NREQ  per-requester accept.
- out_valid  output  1  shared bus valid.
- out_data  output  DW  shared bus data.
- out_last  output  1  shared bus last (packet end or forced burst end).
- out_ready  input  1  downstream accept.
- out_src  output  SW  index of the currently granted requester.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset: rst sampled low at a rising edge gives:
  - state=IDLE, last_grant=NREQ-1, beat_cnt=0;
  - out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, req_ready=0.
- Reset mid-burst: any in-flight beat is abandoned; the bus is idle on the next cycle.
- States: IDLE, GRANT.
- IDLE:
  - All req_ready=0 and out_valid=0.
  - If any req_valid, register grant g = first set req_valid searching last_grant+1, +2, ... with modulo-NREQ wrap.
  - Then go to GRANT and clear beat_cnt. This costs 1 cycle of arbitration latency.
  - If no req_valid, stay in IDLE.
- GRANT (combinational pass-through of requester g):
  - out_valid=req_valid[g], out_data=req_data[g], out_src=g, busy=1.
  - req_ready[g]=out_ready; all other req_ready=0.
  - out_data is 0 whenever out_valid=0.
  - out_last = req_last[g] OR (beat_cnt==MAX_BURST-1).
  - Transfer = out_valid & out_ready. beat_cnt increments by 1 on each transfer.
- Release:
  - Release occurs on a transfer with out_last=1. Then last_grant<=g, state<=IDLE.
  - The next grant therefore starts 2 cycles after the releasing beat: one IDLE bubble, then GRANT.
- Requester drops req_valid mid-burst: the grant is held indefinitely and out_valid=0 meanwhile. There is no timeout.
- Forced release at MAX_BURST beats without req_last: the requester re-enters arbitration with lowest priority. Its next beat appears in a later grant.
- Requests arriving while in GRANT: ignored until IDLE. Only the req_valid value sampled in IDLE decides the winner.
- Simultaneous requests: pure rotation from last_grant. No fixed priority except immediately after reset, where requester 0 wins.
- out_ready low: the beat stalls and beat_cnt holds. The data and last of requester g must stay stable (upstream rule).
- MAX_BURST=1: every beat carries out_last=1 and forces a release.
- Requester-side interface is combinational to the output. Grant, state, beat_cnt and last_grant are registered.

Test Plan:
- Reset then req_valid=4'b0001 with 2-beat packet (A0, A1+last), out_ready=1:
  - grant 0 one cycle after request;
  - out_data=A0 then A1, out_last on A1, out_src=0;
  - IDLE after the release.
- req_valid=4'b1111 held, each requester sending 1-beat packets:
  - grants ordered 0,1,2,3,0;
  - each grant separated by one IDLE cycle;
  - req_ready one-hot and matching out_src.
- Requester 2 streams 10 beats without last, MAX_BURST=4, requester 1 also valid:
  - grants 2 (4 beats, 4th with out_last=1), then 1, then 2 again;
  - out_last asserted on beats 4 and 8 of requester 2.
- Granted requester 1, out_ready toggled 1,0,0,1 on beat 0:
  - out_valid and out_data held stable through both stall cycles;
  - beat_cnt unchanged;
  - exactly one transfer counted.
- rst low during beat 2 of a 4-beat grant:
  - next cycle out_valid=0, busy=0, req_ready=0;
  - after rst goes high with req_valid=4'b0110, requester 1 granted first.
- Granted requester 3 drops req_valid for 5 cycles mid-packet while requester 0 is valid:
  - out_valid=0 for those 5 cycles with grant held, out_src=3;
  - requester 0 granted only after requester 3's last beat.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin share of one DW-bit streaming bus among NREQ requesters, capped at MAX_BURST beats per grant.
// One IDLE cycle of arbitration before each grant; out_ready passes straight through to the granted requester only.
module rr_bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4,
   localparam int SW       = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    req_ready,
   output logic               out_valid,
   output logic [DW-1:0]      out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic [SW-1:0]      out_src,
   output logic               busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [SW-1:0] grant;
   logic [SW-1:0] last_grant;
   logic [7:0]    beat_cnt;
   logic [SW-1:0] next_grant;
   logic          found;
   int            idx;

   // Rotating search starting just after the previous winner.
   always_comb begin
      next_grant = last_grant;
      found      = 1'b0;
      idx        = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            next_grant = SW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_src   = '0;
      busy      = 1'b0;
      if (state == GRANT) begin
         busy             = 1'b1;
         out_src          = grant;
         out_valid        = req_valid[grant];
         out_data         = req_valid[grant] ? req_data[grant*DW +: DW] : '0;
         out_last         = req_last[grant] | (beat_cnt == 8'(MAX_BURST - 1));
         req_ready[grant] = out_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= SW'(NREQ - 1);
         beat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant    <= next_grant;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (out_valid && out_ready) begin
                  if (out_last) begin
                     last_grant <= grant;
                     beat_cnt   <= '0;
                     state      <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized and directed bench for rr_bus_arbiter against a packet-queue reference model.
module tb_rr_bus_arbiter;
   localparam int NREQ      = 4;
   localparam int DW        = 16;
   localparam int MAX_BURST = 4;
   localparam int SW        = $clog2(NREQ);

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic               out_last;
   logic               out_ready;
   logic [SW-1:0]      out_src;
   logic               busy;

   rr_bus_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .out_src(out_src), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pending beats per requester, front = beat currently offered.
   beat_t q[NREQ][$];
   int    gap_cnt[NREQ];
   int    glog[$];
   bit    prev_busy;
   int    n_checks = 0;
   int    n_err    = 0;

   // Reference: owner = -1 when no grant is held.
   int m_owner;
   int m_last;
   int m_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic rst_v, input logic rdy_v);
      logic [NREQ-1:0] e_rdy;
      logic            e_vld, e_last, xfer;
      logic [DW-1:0]   e_dat;
      @(negedge clk);
      rst       = rst_v;
      out_ready = rdy_v;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]          = (q[i].size() > 0) && (gap_cnt[i] == 0);
         req_data[i*DW +: DW]  = (q[i].size() > 0) ? q[i][0].d : '0;
         req_last[i]           = (q[i].size() > 0) ? q[i][0].l : 1'b0;
      end
      #1;
      e_rdy = '0; e_vld = 1'b0; e_last = 1'b0; e_dat = '0;
      if (m_owner >= 0) begin
         e_vld          = req_valid[m_owner];
         e_dat          = e_vld ? q[m_owner][0].d : '0;
         e_last         = req_last[m_owner] || (m_cnt == MAX_BURST - 1);
         e_rdy[m_owner] = rdy_v;
         check_eq("src", out_src, m_owner);
      end
      check_eq("busy", busy, m_owner >= 0);
      check_eq("valid", out_valid, e_vld);
      check_eq("data", out_data, e_dat);
      check_eq("last", out_last, e_last);
      check_eq("ready", req_ready, e_rdy);
      if (busy && !prev_busy) glog.push_back(int'(out_src));
      prev_busy = busy;
      xfer = (m_owner >= 0) && e_vld && rdy_v;
      if (xfer) void'(q[m_owner].pop_front());
      if (!rst_v) begin
         m_owner = -1; m_last = NREQ - 1; m_cnt = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && req_valid[(m_last + k) % NREQ]) begin
               m_owner = (m_last + k) % NREQ;
               m_cnt   = 0;
            end
         end
      end else if (xfer) begin
         if (e_last) begin
            m_last  = m_owner;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end
      for (int i = 0; i < NREQ; i++) if (gap_cnt[i] > 0) gap_cnt[i]--;
   endtask

   task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++) begin
         beat_t bt;
         bt.d = base + DW'(b);
         bt.l = (b == len - 1);
         q[r].push_back(bt);
      end
   endtask

   task automatic drain(input int rdy_pct);
      int  n = 0;
      bit  empty;
      do begin
         cycle(1'b1, $urandom_range(99) < rdy_pct);
         empty = 1'b1;
         for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) empty = 1'b0;
         n++;
      end while (!(empty && m_owner < 0) && n < 1000);
      if (n >= 1000) check_eq("drain_timeout", 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) begin
         q[i].delete();
         gap_cnt[i] = 0;
      end
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      glog.delete();
   endtask

   task automatic check_log(input string tag, input int e0, input int e1, input int e2,
                            input int e3, input int e4, input int n);
      int e[5];
      e = '{e0, e1, e2, e3, e4};
      check_eq({tag, "_n"}, glog.size(), n);
      for (int i = 0; i < n && i < glog.size(); i++) check_eq(tag, glog[i], e[i]);
   endtask

   initial begin
      rst = 1'b0; out_ready = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      m_owner = -1; m_last = NREQ - 1; m_cnt = 0; prev_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) gap_cnt[i] = 0;

      do_reset();
      check_eq("rst_src", out_src, 0);

      // Single two-beat packet from requester 0.
      push_pkt(0, 2, 16'hA000);
      drain(100);
      check_log("glog_single", 0, 0, 0, 0, 0, 1);

      // All four valid with one-beat packets; requester 0 has two.
      do_reset();
      for (int i = 0; i < NREQ; i++) push_pkt(i, 1, DW'(16'h1000 * (i + 1)));
      push_pkt(0, 1, 16'h1100);
      drain(100);
      check_log("glog_rot", 0, 1, 2, 3, 0, 5);

      // Ten beats from requester 2 split by the burst cap, requester 1 interleaved.
      do_reset();
      push_pkt(2, 10, 16'h2000);
      cycle(1'b1, 1'b1);
      push_pkt(1, 1, 16'h1500);
      drain(100);
      check_log("glog_burst", 2, 1, 2, 2, 0, 4);

      // Downstream stall on the first beat of requester 1.
      do_reset();
      push_pkt(1, 2, 16'hB000);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      drain(100);
      check_log("glog_stall", 1, 0, 0, 0, 0, 1);

      // Reset in the middle of a four-beat grant.
      do_reset();
      push_pkt(0, 4, 16'hC000);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      q[0].delete();
      glog.delete();
      push_pkt(1, 1, 16'hC100);
      push_pkt(2, 1, 16'hC200);
      drain(100);
      check_log("glog_rst", 1, 2, 0, 0, 0, 2);

      // Requester 3 goes quiet for five cycles mid-packet.
      do_reset();
      push_pkt(3, 3, 16'hD000);
      cycle(1'b1, 1'b1);
      push_pkt(0, 1, 16'hD100);
      cycle(1'b1, 1'b1);
      gap_cnt[3] = 5;
      drain(100);
      check_log("glog_gap", 3, 0, 0, 0, 0, 2);

      // Random traffic, gaps, stalls and occasional resets.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() < 8 && $urandom_range(99) < 10)
               push_pkt(i, $urandom_range(6, 1), DW'($urandom));
            if (gap_cnt[i] == 0 && $urandom_range(99) < 5) gap_cnt[i] = $urandom_range(3, 1);
         end
         cycle(!($urandom_range(999) < 2), $urandom_range(99) < 75);
      end
      for (int i = 0; i < NREQ; i++) gap_cnt[i] = 0;
      drain(80);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
